// File: rtl/seg_disp_sched.sv
// Seven-segment page scheduler: rotates four measurement sources and pre-empts them with a timed alert page.
// Optional build macro SEG_SCHED_BLINK_EN blinks the display enable while the alert page is shown.
module seg_disp_sched #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DWELL_MS = 2000,
    parameter int ALERT_MS = 1000,
    parameter int BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [79:0] src_data,
    input  logic [23:0] src_point,
    input  logic [3:0]  src_sign,
    input  logic [3:0]  src_valid,
    input  logic        key_next,
    input  logic        alert_req,
    input  logic [19:0] alert_data,
    output logic        alert_ack,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        en,
    output logic [1:0]  page
);
    localparam int MS_DIV = CLK_FREQ / 1000;
    localparam int MS_W   = $clog2(MS_DIV + 1);
    localparam int DW_MAX = (DWELL_MS > ALERT_MS) ? DWELL_MS : ALERT_MS;
    localparam int DW_W   = $clog2(DW_MAX + 1);
    localparam logic [19:0] MAX_VAL = 20'd999999;

    if (MS_DIV < 2 || DWELL_MS < 1 || ALERT_MS < 1 || BLINK_MS < 1) begin : g_cfg_check
        $error("seg_disp_sched: invalid timing parameters");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, ALERT = 2'd2} state_t;

    state_t          state, state_n;
    logic [1:0]      cur, cur_n;
    logic            restart;
    logic [MS_W-1:0] ms_cnt;
    logic            ms_tick;
    logic [DW_W-1:0] dwell_cnt;
    logic            any_valid, dwell_done, alert_done, advance;
    logic [19:0]     sel_data, data_d;
    logic [5:0]      sel_point, point_d;
    logic [1:0]      nxt_idx, low_idx, probe;
    logic            nxt_found;
    logic            sign_d, en_d, ack_d, alert_en;

    function automatic logic [19:0] clamp(input logic [19:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    assign page       = cur;
    assign ms_tick    = (ms_cnt == MS_W'(MS_DIV - 1));
    assign any_valid  = |src_valid;
    assign dwell_done = ms_tick && (dwell_cnt == DW_W'(DWELL_MS - 1));
    assign alert_done = ms_tick && (dwell_cnt == DW_W'(ALERT_MS - 1));
    assign advance    = dwell_done || key_next || !src_valid[cur];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ms_cnt <= '0;
        else if (ms_tick) ms_cnt <= '0;
        else              ms_cnt <= ms_cnt + MS_W'(1);
    end

    // restart also covers a page change and the "no other source" re-dwell
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                dwell_cnt <= '0;
        else if (state_n != state || restart)      dwell_cnt <= '0;
        else if (ms_tick && state != IDLE)         dwell_cnt <= dwell_cnt + DW_W'(1);
    end

    always_comb begin
        sel_data  = src_data[19:0];
        sel_point = src_point[5:0];
        case (cur)
            2'd1: begin sel_data = src_data[39:20]; sel_point = src_point[11:6];  end
            2'd2: begin sel_data = src_data[59:40]; sel_point = src_point[17:12]; end
            2'd3: begin sel_data = src_data[79:60]; sel_point = src_point[23:18]; end
            default: ;
        endcase
    end

    always_comb begin
        nxt_idx   = cur;
        nxt_found = 1'b0;
        probe     = cur;
        for (int k = 1; k < 4; k++) begin
            probe = cur + 2'(k);
            if (!nxt_found && src_valid[probe]) begin
                nxt_found = 1'b1;
                nxt_idx   = probe;
            end
        end
        low_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (src_valid[k]) low_idx = 2'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cur   <= 2'd0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
        end
    end

    // alert_req outranks every advance reason, so cur stays put on pre-emption
    always_comb begin
        state_n = state;
        cur_n   = cur;
        restart = 1'b0;
        case (state)
            IDLE: begin
                if (alert_req) state_n = ALERT;
                else if (any_valid) begin
                    state_n = ROTATE;
                    cur_n   = low_idx;
                end
            end
            ROTATE: begin
                if (alert_req)       state_n = ALERT;
                else if (!any_valid) state_n = IDLE;
                else if (advance) begin
                    restart = 1'b1;
                    if (nxt_found) cur_n = nxt_idx;
                end
            end
            ALERT: begin
                if (alert_done) state_n = any_valid ? ROTATE : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef SEG_SCHED_BLINK_EN
    localparam int BK_W = $clog2(BLINK_MS + 1);
    logic [BK_W-1:0] blink_cnt;
    logic            blink_on;

    // held at phase 0 / lit outside ALERT, which restarts the blink on every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (state != ALERT) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (ms_tick) begin
            if (blink_cnt == BK_W'(BLINK_MS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BK_W'(1);
            end
        end
    end

    assign alert_en = blink_on || (state_n == ROTATE);
`else
    assign alert_en = 1'b1;
`endif

    always_comb begin
        data_d  = data;
        point_d = point;
        sign_d  = sign;
        en_d    = en;
        ack_d   = (state != ALERT) && (state_n == ALERT);
        case (state)
            IDLE: en_d = 1'b0;
            ROTATE: begin
                data_d  = clamp(sel_data);
                point_d = sel_point;
                sign_d  = src_sign[cur];
                en_d    = 1'b1;
            end
            ALERT: begin
                data_d  = clamp(alert_data);
                point_d = '0;
                sign_d  = 1'b0;
                en_d    = alert_en;
            end
            default: en_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            point     <= '0;
            sign      <= 1'b0;
            en        <= 1'b0;
            alert_ack <= 1'b0;
        end else begin
            data      <= data_d;
            point     <= point_d;
            sign      <= sign_d;
            en        <= en_d;
            alert_ack <= ack_d;
        end
    end
endmodule
